// File: rtl/sram_mem_ctrl.sv
// Word-wide load/store front end for a 16-bit asynchronous SRAM.
// Optional one-entry read buffer when SRAM_READ_BUFFER_EN is defined.
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] ST_val,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [16:0] word_q;
  logic [31:0] st_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        start;
  logic        hit;
  logic        last;
  logic        busy;
  logic        drive;
  logic        cap_lo;
  logic        cap_hi;
  logic [31:0] off;
  logic [16:0] word_in;
  logic        unused_ok;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign start   = (state_q == S_IDLE) & req;
  assign off     = address - BASE_ADDR;
  assign word_in = off[18:2];
  assign last    = (cnt_q == LAST);
  assign busy    = (state_q == S_LOW) | (state_q == S_HIGH);
  assign drive   = busy & wr_q;
  assign cap_lo  = (state_q == S_LOW) & last & ~wr_q;
  assign cap_hi  = (state_q == S_HIGH) & last & ~wr_q;

  assign unused_ok = ^{off[31:19], off[1:0]};

`ifdef SRAM_READ_BUFFER_EN
  logic        bv_q;
  logic [16:0] btag_q;
  logic [31:0] bdata_q;

  assign hit = MEM_R_EN & ~MEM_W_EN & bv_q & (btag_q == word_in);

  // Remember the last loaded word; drop it when a store targets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bv_q    <= 1'b0;
      btag_q  <= '0;
      bdata_q <= '0;
    end else if (state_q == S_DONE && !wr_q) begin
      bv_q    <= 1'b1;
      btag_q  <= word_q;
      bdata_q <= rdata_q;
    end else if (start && MEM_W_EN && btag_q == word_in) begin
      bv_q    <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Next state and dwell counter; counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req) state_d = hit ? S_DONE : S_LOW;
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, latched request and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      st_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        wr_q   <= MEM_W_EN;
        word_q <= word_in;
        st_q   <= ST_val;
      end
      if (cap_lo) rdata_q[15:0]  <= SRAM_DQ;
      if (cap_hi) rdata_q[31:16] <= SRAM_DQ;
`ifdef SRAM_READ_BUFFER_EN
      if (start && hit) rdata_q <= bdata_q;
`endif
    end
  end

  assign SRAM_DQ   = drive ? ((state_q == S_HIGH) ? st_q[31:16]
                                                  : st_q[15:0])
                           : 16'hzzzz;
  assign SRAM_ADDR = {word_q, (state_q == S_HIGH)};
  assign SRAM_WE_N = ~drive;
  assign SRAM_OE_N = ~(busy & ~wr_q);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign read_data = rdata_q;
  assign ready     = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: SRAM device model, transaction-level
// reference model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LEN  = 2*W + 1;
`ifdef SRAM_READ_BUFFER_EN
  localparam int          HIT_RL = 1;
`else
  localparam int          HIT_RL = LEN;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] st = '0;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] dq;
  logic [17:0] saddr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  logic [15:0] sram [0:262143];
  logic [15:0] sram_rd;

  // reference model state
  logic [31:0] refm [0:131071];
  int          ph = -1;
  int          len = LEN;
  bit          m_wr = 1'b0;
  logic [16:0] m_word = '0;
  logic [31:0] m_st = '0;
  logic [31:0] m_rd = '0;
  bit          bv = 1'b0;
  logic [16:0] btag = '0;
  bit          chk_en = 1'b0;
  int          rl = 0;
  int          nvec = 0;
  int          nbad = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(r_en), .MEM_W_EN(w_en),
    .address(addr), .ST_val(st),
    .read_data(rdata), .ready(ready),
    .SRAM_DQ(dq), .SRAM_ADDR(saddr),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // SRAM device
  assign sram_rd = sram[saddr];
  assign dq = (!oe_n && we_n) ? sram_rd : 16'bz;
  always @(posedge clk) if (!we_n) sram[saddr] <= dq;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h want %h (t=%0t ph=%0d)", n, a, e,
               $time, ph);
    end
  endtask

  function automatic logic [16:0] wordof(input logic [31:0] a);
    return 17'((a - BASE) >> 2);
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (!ready) rl++;
      chk("strobes", 32'({ce_n, ub_n, lb_n}), 32'd0);
      if (ph < 0) begin
        chk("idle_rdy", 32'(ready), 32'd1);
        chk("idle_we", 32'(we_n), 32'd1);
        chk("idle_oe", 32'(oe_n), 32'd1);
        chk("idle_rdata", rdata, m_rd);
      end else if (ph == 0) begin
        chk("req_rdy", 32'(ready), 32'd0);
        chk("req_we", 32'(we_n), 32'd1);
        chk("req_oe", 32'(oe_n), 32'd1);
      end else if (ph == len) begin
        chk("done_rdy", 32'(ready), 32'd1);
        chk("done_we", 32'(we_n), 32'd1);
        chk("done_oe", 32'(oe_n), 32'd1);
        chk("done_rdata", rdata, m_rd);
      end else begin
        chk("busy_rdy", 32'(ready), 32'd0);
        chk("addr", 32'(saddr), 32'({m_word, ph > W}));
        chk("busy_we", 32'(we_n), 32'(!m_wr));
        chk("busy_oe", 32'(oe_n), 32'(m_wr));
        if (m_wr)
          chk("dq", 32'(dq), 32'((ph > W) ? m_st[31:16] : m_st[15:0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ph = -1;
      r_en = 1'b0; w_en = 1'b0;
    end
  endtask

  // One request; abort_ph>0 asserts rst during that phase.
  task automatic xact(input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] v, input int abort_ph = 0);
    logic [16:0] wd;
    bit hit;
    wd  = wordof(a);
    hit = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
    hit = !w && bv && (btag == wd);
`endif
    @(posedge clk); #1;
    r_en = r; w_en = w; addr = a; st = v;
    m_wr = w; m_word = wd; m_st = v;
    len = hit ? 1 : LEN;
    rl = 0;
    ph = 0;
    if (w && btag == wd) bv = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      ph = k;
      if (k < len) begin
        r_en = 1'($urandom); w_en = 1'($urandom);
        addr = $urandom; st = $urandom;
      end else begin
        r_en = 1'b0; w_en = 1'b0;
        if (w) refm[wd] = v;
        else begin
          m_rd = refm[wd];
          bv = 1'b1;
          btag = wd;
        end
      end
      if (abort_ph != 0 && k == abort_ph) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ph = -1;
        r_en = 1'b0; w_en = 1'b0;
        m_rd = '0;
        bv = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, v;
    int kk;
    for (int i = 0; i < 262144; i++) sram[i] = '0;
    for (int i = 0; i < 131072; i++) refm[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    xact(1'b0, 1'b1, 32'd1024, 32'h1234ABCD);
    chk("st0_lo", 32'(sram[0]), 32'h0000ABCD);
    chk("st0_hi", 32'(sram[1]), 32'h00001234);
    chk("st0_rl", rl, 7);
    xact(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("ld0_data", rdata, 32'h1234ABCD);
    chk("ld0_rl", rl, 7);
    idle(2);

    xact(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    chk("st1_lo", 32'(sram[2]), 32'h0000BEEF);
    chk("st1_hi", 32'(sram[3]), 32'h0000DEAD);
    xact(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("ld1_data", rdata, 32'hDEADBEEF);

    xact(1'b1, 1'b1, 32'd1032, 32'h5);
    chk("both_rl", rl, 7);
    chk("both_mem", 32'(sram[4]), 32'h5);
    xact(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("both_ld", rdata, 32'h5);
    idle(1);

    xact(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("buf_miss_rl", rl, 7);
    xact(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("buf_hit_rl", rl, HIT_RL);
    chk("buf_hit_data", rdata, 32'h1234ABCD);
    xact(1'b0, 1'b1, 32'd1024, 32'h0BADF00D);
    xact(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("buf_inv_rl", rl, 7);
    chk("buf_inv_data", rdata, 32'h0BADF00D);

    xact(1'b0, 1'b1, BASE + 32'd4 * 32'd131072, 32'hA5A55A5A);
    xact(1'b1, 1'b0, 32'd1024, 32'h0);
    chk("wrap_data", rdata, 32'hA5A55A5A);

    xact(1'b0, 1'b1, 32'd1060, 32'hCAFEF00D, W + 2);
    @(negedge clk);
    chk("abort_we", 32'(we_n), 32'd1);
    chk("abort_rdy", 32'(ready), 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    xact(1'b0, 1'b1, 32'd1060, 32'h13579BDF);

    for (int n = 0; n < 70; n++) begin
      kk = $urandom_range(0, 9);
      if (kk < 8)
        a = BASE + 32'(4 * kk) + 32'($urandom_range(0, 3));
      else if (kk == 8)
        a = BASE + 32'd4 * (32'd131072 + 32'($urandom_range(0, 7)));
      else
        a = $urandom;
      v = $urandom;
      case ($urandom_range(0, 3))
        0: xact(1'b0, 1'b1, a, v);
        1: xact(1'b1, 1'b1, a, v);
        default: xact(1'b1, 1'b0, a, v);
      endcase
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3: clocks each SRAM half-word access is held (legal range 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024: first byte address of data memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port MEM_R_EN, input, 1 bit: load request from the MEM stage.
REQ-006 SHALL have port MEM_W_EN, input, 1 bit: store request from the MEM stage.
REQ-007 SHALL have port address, input, 32 bits: byte address (ALU result).
REQ-008 SHALL have port ST_val, input, 32 bits: store data.
REQ-009 SHALL have port read_data, output, 32 bits: load result.
REQ-010 SHALL have port ready, output, 1 bit: access complete; the pipeline freeze is ~ready.
REQ-011 SHALL have port SRAM_DQ, inout, 16 bits: SRAM data bus.
REQ-012 SHALL have port SRAM_ADDR, output, 18 bits: SRAM half-word address.
REQ-013 SHALL have ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N and SRAM_LB_N, outputs, 1 bit each: active-low SRAM strobes.

Function
REQ-014 SHALL implement the FSM states IDLE, LOW, HIGH and DONE.
REQ-015 SHALL transition IDLE->LOW when MEM_R_EN or MEM_W_EN is sampled high.
REQ-016 SHALL transition LOW->HIGH and HIGH->DONE each after WAIT_CYCLES clocks, counted by an internal 4-bit counter that clears on every state entry.
REQ-017 SHALL transition DONE->IDLE unconditionally after one clock.
REQ-018 SHALL compute word = (address - BASE_ADDR) >> 2, and SHALL drive SRAM_ADDR = {word[16:0], 1'b0} in LOW and {word[16:0], 1'b1} in HIGH.
REQ-019 SHALL, on a store, drive SRAM_DQ with ST_val[15:0] in LOW and ST_val[31:16] in HIGH, with SRAM_WE_N=0 for every cycle of LOW and HIGH.
REQ-020 SHALL, on a load, hold SRAM_DQ at high-Z with SRAM_OE_N=0.
REQ-021 SHALL, on a load, capture SRAM_DQ into read_data[15:0] on the last cycle of LOW and into read_data[31:16] on the last cycle of HIGH.
REQ-022 SHALL hold read_data stable from DONE until the next load's capture.
REQ-023 SHALL keep SRAM_CE_N, SRAM_UB_N and SRAM_LB_N at 0 at all times.
REQ-024 SHALL keep SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ high-Z in IDLE and DONE.
REQ-025 SHALL drive ready combinationally as (state==DONE) | (state==IDLE & ~MEM_R_EN & ~MEM_W_EN).
REQ-026 SHALL keep ready low for exactly 2*WAIT_CYCLES+1 cycles for an uncached request.
REQ-027 SHALL latch the request type, address and ST_val on IDLE exit and ignore input changes until IDLE is re-entered.
REQ-028 SHALL treat MEM_R_EN and MEM_W_EN both high as a store (store wins).
REQ-029 SHALL let word addresses wrap modulo 2^17 with no error flag.
REQ-030 SHALL start a new request sampled in the IDLE cycle following DONE normally, with no dead cycle beyond IDLE.

Reset
REQ-031 SHALL, with rst high at a clock edge, force state=IDLE, clear the counter, clear read_data to 0 and clear the latched request.
REQ-032 SHALL, in the cycle after reset, drive SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ high-Z.
REQ-033 SHALL apply reset mid-access the same way, abandoning the access; a store may have written only its low half.

Configuration
REQ-034 SHALL, when SRAM_READ_BUFFER_EN is defined, implement a one-entry buffer {valid, word tag, 32-bit data} that is loaded at each load's DONE.
REQ-035 SHALL, when SRAM_READ_BUFFER_EN is defined, let a load whose word equals a valid tag go IDLE->DONE directly, with ready low 1 cycle and read_data taken from the buffer.
REQ-036 SHALL, when SRAM_READ_BUFFER_EN is defined, clear the buffer valid bit when any store to the tagged word enters LOW, and clear it on reset.
REQ-037 SHALL, when SRAM_READ_BUFFER_EN is not defined, omit the buffer and give every load the full 2*WAIT_CYCLES+1 latency.

Verification
REQ-038 SHALL cover: store 0x1234ABCD to address 1024 -> SRAM_ADDR 0 written with 0xABCD, then SRAM_ADDR 1 with 0x1234; ready low 7 cycles.
REQ-039 SHALL cover: load from address 1024 after that store -> read_data=0x1234ABCD in DONE; ready low 7 cycles.
REQ-040 SHALL cover: store 0xDEADBEEF to address 1028, then load from address 1028 -> SRAM_ADDR 2 and 3 accessed; read_data=0xDEADBEEF.
REQ-041 SHALL cover: MEM_R_EN and MEM_W_EN both high, ST_val=0x5 -> SRAM_WE_N low; a subsequent load returns 0x5.
REQ-042 SHALL cover: rst asserted in the 2nd cycle of HIGH -> IDLE on the next cycle with SRAM_WE_N=1, DQ high-Z and ready=1 while no request is present.
REQ-043 SHALL cover: with SRAM_READ_BUFFER_EN, two consecutive loads from address 1024 -> second load has ready low 1 cycle; an intervening store to 1024 restores the 7-cycle latency.
